// File: rtl/jacobi_sweep_sequencer_if.sv
// jacobi_sweep_sequencer_if: control/address bundle between the Jacobi sequencer and its datapath.
// The abort signal exists only when JACOBI_SEQ_ABORT_EN is defined.
interface jacobi_sweep_sequencer_if #(
    parameter int AW = 16,
    parameter int IW = 16
);
    logic          start;
    logic [7:0]    n;
    logic [IW-1:0] max_iter;
    logic          conv_in;
    logic          div_done;
`ifdef JACOBI_SEQ_ABORT_EN
    logic          abort;
`endif
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic          ram_wr;
    logic [1:0]    rd_tag;
    logic          rd_diag;
    logic          row_clr;
    logic          div_start;
    logic          busy;
    logic          done;
    logic          err;
    logic          converged;
    logic [IW-1:0] iter_count;
    logic [AW-1:0] x_base;

    // Controller side: drives the solve request and datapath status.
    modport master (
`ifdef JACOBI_SEQ_ABORT_EN
        output abort,
`endif
        output start, n, max_iter, conv_in, div_done,
        input  ram_addr, ram_rd, ram_wr, rd_tag, rd_diag, row_clr, div_start,
        input  busy, done, err, converged, iter_count, x_base
    );

    // Sequencer side.
    modport slave (
`ifdef JACOBI_SEQ_ABORT_EN
        input  abort,
`endif
        input  start, n, max_iter, conv_in, div_done,
        output ram_addr, ram_rd, ram_wr, rd_tag, rd_diag, row_clr, div_start,
        output busy, done, err, converged, iter_count, x_base
    );
endinterface

// File: rtl/jacobi_sweep_sequencer.sv
// jacobi_sweep_sequencer: walks A, x_old and b for each row of an N x N Jacobi sweep,
// hands the divide to the datapath, writes x_new into the ping-pong buffer and
// repeats sweeps until convergence or the iteration limit.
// Memory map: A at 0 (row-major), b at n*n, xbuf0 at n*n+n, xbuf1 at n*n+2n.
// Optional feature: define JACOBI_SEQ_ABORT_EN to add the abort input.
//
// state     | meaning
// IDLE      | waiting for start
// INIT      | forming n*n by repeated addition, validating n / max_iter
// ROW       | clear the row accumulator
// RD_A      | read A[i][j]
// RD_X      | read x_old[j]
// RD_B      | read b[i]
// DIV       | divide in flight, waiting for div_done
// WR_X      | write x_new[i]
// SWEEP_END | count the sweep, flip buffers, test for termination
// DONE      | one-cycle completion pulse
module jacobi_sweep_sequencer #(
    parameter int N_MAX = 16,
    parameter int AW    = 16,
    parameter int IW    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    jacobi_sweep_sequencer_if.slave bus
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INIT      = 4'd1;
    localparam logic [3:0] S_ROW       = 4'd2;
    localparam logic [3:0] S_RD_A      = 4'd3;
    localparam logic [3:0] S_RD_X      = 4'd4;
    localparam logic [3:0] S_RD_B      = 4'd5;
    localparam logic [3:0] S_DIV       = 4'd6;
    localparam logic [3:0] S_WR_X      = 4'd7;
    localparam logic [3:0] S_SWEEP_END = 4'd8;
    localparam logic [3:0] S_DONE      = 4'd9;

    localparam logic [7:0] N_MAX_B = 8'(N_MAX);

    logic [3:0]    state_q, state_d;
    logic [7:0]    n_q, n_d;
    logic [IW-1:0] max_iter_q, max_iter_d;
    logic [AW-1:0] nn_q, nn_d;
    logic [7:0]    k_q, k_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          parity_q, parity_d;
    logic          div_started_q, div_started_d;
    logic          err_q, err_d;
    logic          conv_q, conv_d;
    logic [AW-1:0] x_base_q, x_base_d;
    logic [1:0]    rd_tag_q, rd_tag_d;
    logic          rd_diag_q, rd_diag_d;

    logic [AW-1:0] n_aw;
    logic [AW-1:0] xb0, xb1, xrd_base, xwr_base;
    logic [AW-1:0] ram_addr_w;
    logic          last_j, last_i, init_last;
    logic          abort_w;

    assign n_aw      = AW'(n_q);
    assign xb0       = nn_q + n_aw;
    assign xb1       = xb0 + n_aw;
    assign xrd_base  = parity_q ? xb1 : xb0;
    assign xwr_base  = parity_q ? xb0 : xb1;
    assign last_j    = (j_q == n_q - 8'd1);
    assign last_i    = (i_q == n_q - 8'd1);
    assign init_last = (n_q == 8'd0) || (({1'b0, k_q} + 9'd1) >= {1'b0, n_q});

`ifdef JACOBI_SEQ_ABORT_EN
    assign abort_w = bus.abort && (state_q != S_IDLE) && (state_q != S_DONE);
`else
    assign abort_w = 1'b0;
`endif

    // Next-state and datapath-control register updates.
    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        max_iter_d    = max_iter_q;
        nn_d          = nn_q;
        k_d           = k_q;
        i_d           = i_q;
        j_d           = j_q;
        row_base_d    = row_base_q;
        iter_d        = iter_q;
        parity_d      = parity_q;
        err_d         = err_q;
        conv_d        = conv_q;
        x_base_d      = x_base_q;
        div_started_d = (state_q == S_DIV);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_d        = bus.n;
                    max_iter_d = bus.max_iter;
                    nn_d       = '0;
                    k_d        = 8'd0;
                    iter_d     = '0;
                    err_d      = 1'b0;
                    conv_d     = 1'b0;
                    x_base_d   = '0;
                    state_d    = S_INIT;
                end
            end
            S_INIT: begin
                nn_d = nn_q + n_aw;
                k_d  = k_q + 8'd1;
                if (init_last) begin
                    if ((n_q == 8'd0) || (n_q > N_MAX_B)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (max_iter_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        i_d        = 8'd0;
                        row_base_d = '0;
                        iter_d     = '0;
                        state_d    = S_ROW;
                    end
                end
            end
            S_ROW: begin
                j_d     = 8'd0;
                state_d = S_RD_A;
            end
            S_RD_A: state_d = S_RD_X;
            S_RD_X: begin
                if (last_j) begin
                    state_d = S_RD_B;
                end else begin
                    j_d     = j_q + 8'd1;
                    state_d = S_RD_A;
                end
            end
            S_RD_B: state_d = S_DIV;
            S_DIV: begin
                if (bus.div_done) state_d = S_WR_X;
            end
            S_WR_X: begin
                if (last_i) begin
                    state_d = S_SWEEP_END;
                end else begin
                    i_d        = i_q + 8'd1;
                    row_base_d = row_base_q + n_aw;
                    state_d    = S_ROW;
                end
            end
            S_SWEEP_END: begin
                iter_d   = iter_q + 1'b1;
                parity_d = ~parity_q;
                if (bus.conv_in) begin
                    conv_d   = 1'b1;
                    x_base_d = xwr_base;
                    state_d  = S_DONE;
                end else if ((iter_q + 1'b1) == max_iter_q) begin
                    x_base_d = xwr_base;
                    state_d  = S_DONE;
                end else begin
                    i_d        = 8'd0;
                    row_base_d = '0;
                    state_d    = S_ROW;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort keeps the sweep count; x_base points at the last fully written buffer.
        if (abort_w) begin
            err_d    = 1'b1;
            conv_d   = 1'b0;
            x_base_d = (state_q == S_SWEEP_END) ? xwr_base : xrd_base;
            state_d  = S_DONE;
        end
    end

    // RAM address for the current access state.
    always_comb begin
        ram_addr_w = '0;
        case (state_q)
            S_RD_A:  ram_addr_w = row_base_q + AW'(j_q);
            S_RD_X:  ram_addr_w = xrd_base + AW'(j_q);
            S_RD_B:  ram_addr_w = nn_q + AW'(i_q);
            S_WR_X:  ram_addr_w = xwr_base + AW'(i_q);
            default: ram_addr_w = '0;
        endcase
    end

    // Read-tag decode, registered so it lines up with RAM q.
    always_comb begin
        rd_tag_d  = 2'd0;
        rd_diag_d = 1'b0;
        case (state_q)
            S_RD_A: begin
                rd_tag_d  = 2'd1;
                rd_diag_d = (j_q == i_q);
            end
            S_RD_X:  rd_tag_d = 2'd2;
            S_RD_B:  rd_tag_d = 2'd3;
            default: rd_tag_d = 2'd0;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            n_q           <= 8'd0;
            max_iter_q    <= '0;
            nn_q          <= '0;
            k_q           <= 8'd0;
            i_q           <= 8'd0;
            j_q           <= 8'd0;
            row_base_q    <= '0;
            iter_q        <= '0;
            parity_q      <= 1'b0;
            div_started_q <= 1'b0;
            err_q         <= 1'b0;
            conv_q        <= 1'b0;
            x_base_q      <= '0;
            rd_tag_q      <= 2'd0;
            rd_diag_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            max_iter_q    <= max_iter_d;
            nn_q          <= nn_d;
            k_q           <= k_d;
            i_q           <= i_d;
            j_q           <= j_d;
            row_base_q    <= row_base_d;
            iter_q        <= iter_d;
            parity_q      <= parity_d;
            div_started_q <= div_started_d;
            err_q         <= err_d;
            conv_q        <= conv_d;
            x_base_q      <= x_base_d;
            rd_tag_q      <= rd_tag_d;
            rd_diag_q     <= rd_diag_d;
        end
    end

    assign bus.ram_addr   = ram_addr_w;
    assign bus.ram_rd     = (state_q == S_RD_A) || (state_q == S_RD_X) || (state_q == S_RD_B);
    assign bus.ram_wr     = (state_q == S_WR_X) && !abort_w;
    assign bus.rd_tag     = rd_tag_q;
    assign bus.rd_diag    = rd_diag_q;
    assign bus.row_clr    = (state_q == S_ROW);
    assign bus.div_start  = (state_q == S_DIV) && !div_started_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = err_q;
    assign bus.converged  = conv_q;
    assign bus.iter_count = iter_q;
    assign bus.x_base     = x_base_q;
endmodule

// File: tb/tb_jacobi_sweep_sequencer.sv
// tb_jacobi_sweep_sequencer: randomized bench for jacobi_sweep_sequencer with a
// sweep-level reference model (expected access list built from the memory map).
`timescale 1ns/1ps
module tb_jacobi_sweep_sequencer;
    localparam int AW    = 16;
    localparam int IW    = 16;
    localparam int N_MAX = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jacobi_sweep_sequencer_if #(.AW(AW), .IW(IW)) bus();

    jacobi_sweep_sequencer #(.N_MAX(N_MAX), .AW(AW), .IW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit wr;
        int addr;
        int tag;
        bit diag;
    } acc_t;

    int   checks   = 0;
    int   errors   = 0;
    int   m_parity = 0;
    acc_t exp_q[$];

    // Expected access list for a whole solve, from the memory map and sweep rules.
    task automatic build_expected(input int n, input int mi, input int conv_at,
                                  output int sweeps, output bit conv, output int xb);
        int nn;
        int p;
        nn = n * n;
        exp_q.delete();
        sweeps = 0;
        conv   = 1'b0;
        xb     = 0;
        if (n == 0 || n > N_MAX || mi == 0) return;
        if (conv_at >= 1 && conv_at <= mi) begin
            sweeps = conv_at;
            conv   = 1'b1;
        end else begin
            sweeps = mi;
        end
        p = m_parity;
        for (int s = 0; s < sweeps; s++) begin
            int xr;
            int xw;
            xr = nn + n + p * n;
            xw = nn + n + (1 - p) * n;
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < n; j++) begin
                    exp_q.push_back(acc_t'{wr: 1'b0, addr: i * n + j, tag: 1, diag: (i == j)});
                    exp_q.push_back(acc_t'{wr: 1'b0, addr: xr + j, tag: 2, diag: 1'b0});
                end
                exp_q.push_back(acc_t'{wr: 1'b0, addr: nn + i, tag: 3, diag: 1'b0});
                exp_q.push_back(acc_t'{wr: 1'b1, addr: xw + i, tag: 0, diag: 1'b0});
            end
            xb = xw;
            p  = 1 - p;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.n        = 8'd0;
        bus.max_iter = '0;
        bus.conv_in  = 1'b0;
        bus.div_done = 1'b0;
`ifdef JACOBI_SEQ_ABORT_EN
        bus.abort    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_parity = 0;
    endtask

    // Runs one solve: responds to div_start with random latency, drives conv_in,
    // optionally injects stray start / div_done pulses, checks every access and the result.
    task automatic run_solve(input int n, input int mi, input int conv_at, input int dmax,
                             input bit noise, input string name);
        int   sweeps, xb, cyc, wr_cnt, cd, d, sum_d, rows_clr, divs, exp_cyc, prev_tag;
        bit   conv, exp_err, prev_diag, got_done;
        acc_t e;
        build_expected(n, mi, conv_at, sweeps, conv, xb);
        exp_err = (n == 0 || n > N_MAX);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.n        = 8'(n);
        bus.max_iter = IW'(mi);
        bus.conv_in  = 1'b0;
        bus.div_done = 1'b0;
        cyc = 0; wr_cnt = 0; cd = 0; sum_d = 0; rows_clr = 0; divs = 0;
        prev_tag = 0; prev_diag = 1'b0; got_done = 1'b0;
        while (!got_done && cyc < 20000) begin
            @(negedge clk);
            checks++;
            if (bus.rd_tag !== 2'(prev_tag) || bus.rd_diag !== prev_diag) begin
                errors++;
                $display("FAIL %s rd_tag cyc=%0d got %0d/%0b expected %0d/%0b",
                         name, cyc, bus.rd_tag, bus.rd_diag, prev_tag, prev_diag);
            end
            prev_tag  = 0;
            prev_diag = 1'b0;
            if (bus.ram_rd || bus.ram_wr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra access cyc=%0d rd=%0b wr=%0b addr=%0d expected none",
                             name, cyc, bus.ram_rd, bus.ram_wr, bus.ram_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.ram_wr !== e.wr || bus.ram_rd !== !e.wr || int'(bus.ram_addr) != e.addr) begin
                        errors++;
                        $display("FAIL %s access cyc=%0d got rd=%0b wr=%0b addr=%0d expected wr=%0b addr=%0d",
                                 name, cyc, bus.ram_rd, bus.ram_wr, bus.ram_addr, e.wr, e.addr);
                    end
                    prev_tag  = e.tag;
                    prev_diag = e.diag;
                end
                if (bus.ram_wr) wr_cnt++;
            end
            if (bus.row_clr) rows_clr++;
            if (bus.div_start) begin
                divs++;
                d = int'($urandom_range(dmax, 0));
                sum_d += d;
                if (d == 0) bus.div_done = 1'b1;
                else cd = d;
            end
            if (noise && bus.ram_rd && int'(bus.ram_addr) < n * n && $urandom_range(1, 0) == 1)
                bus.div_done = 1'b1;
            if (bus.done) begin
                got_done = 1'b1;
                if (exp_err || mi == 0) exp_cyc = 1 + ((n > 0) ? n : 1);
                else exp_cyc = 1 + n + sweeps + n * sweeps * (2 * n + 4) + sum_d;
                checks++;
                if (cyc != exp_cyc) begin
                    errors++;
                    $display("FAIL %s done_cycle got %0d expected %0d", name, cyc, exp_cyc);
                end
                checks++;
                if (bus.err !== exp_err || bus.converged !== conv || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s flags got err=%0b conv=%0b busy=%0b expected err=%0b conv=%0b busy=1",
                             name, bus.err, bus.converged, bus.busy, exp_err, conv);
                end
                checks++;
                if (bus.iter_count !== IW'(sweeps)) begin
                    errors++;
                    $display("FAIL %s iter_count got %0d expected %0d", name, bus.iter_count, sweeps);
                end
                if (sweeps > 0) begin
                    checks++;
                    if (bus.x_base !== AW'(xb)) begin
                        errors++;
                        $display("FAIL %s x_base got %0d expected %0d", name, bus.x_base, xb);
                    end
                end
                checks++;
                if (exp_q.size() != 0 || rows_clr != sweeps * n || divs != sweeps * n) begin
                    errors++;
                    $display("FAIL %s counts got left=%0d row_clr=%0d div_start=%0d expected 0/%0d/%0d",
                             name, exp_q.size(), rows_clr, divs, sweeps * n, sweeps * n);
                end
            end
            @(posedge clk); #1;
            bus.start    = (noise && !got_done) ? 1'($urandom_range(1, 0)) : 1'b0;
            bus.div_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) bus.div_done = 1'b1;
            end
            bus.conv_in = (conv_at > 0 && wr_cnt == conv_at * n);
            cyc++;
        end
        if (!got_done) begin
            errors++;
            $display("FAIL %s timeout got no done expected done", name);
            do_reset();
        end else begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s after_done got busy=%0b done=%0b expected 0/0", name, bus.busy, bus.done);
            end
            m_parity = (m_parity + sweeps) % 2;
        end
        bus.conv_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.ram_addr, bus.ram_rd, bus.ram_wr, bus.rd_tag, bus.rd_diag, bus.row_clr, bus.div_start,
             bus.busy, bus.done, bus.err, bus.converged, bus.iter_count, bus.x_base} !== '0) begin
            errors++;
            $display("FAIL reset outputs got addr=%0d rd=%0b wr=%0b busy=%0b done=%0b expected all 0",
                     bus.ram_addr, bus.ram_rd, bus.ram_wr, bus.busy, bus.done);
        end
    endtask

    task automatic test_plan_n2();
        run_solve(2, 1, 0, 1, 1'b0, "plan_n2");
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.n        = 8'd2;
        bus.max_iter = IW'(3);
        bus.div_done = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.div_start) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid reach_div got no div_start expected div_start");
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        m_parity  = 0;
        @(negedge clk);
        checks++;
        if ({bus.ram_addr, bus.ram_rd, bus.ram_wr, bus.rd_tag, bus.rd_diag, bus.row_clr, bus.div_start,
             bus.busy, bus.done, bus.err, bus.converged, bus.iter_count, bus.x_base} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs got addr=%0d rd=%0b wr=%0b busy=%0b tag=%0d expected all 0",
                     bus.ram_addr, bus.ram_rd, bus.ram_wr, bus.busy, bus.rd_tag);
        end
        run_solve(2, 1, 0, 1, 1'b0, "reset_mid_rerun");
    endtask

    task automatic test_converge();
        do_reset();
        run_solve(2, 5, 2, 1, 1'b0, "converge");
    endtask

    task automatic test_bad_n();
        run_solve(0, 3, 0, 1, 1'b0, "n_zero");
        run_solve(17, 3, 0, 1, 1'b0, "n_17");
        run_solve(N_MAX, 1, 0, 2, 1'b0, "n_max");
        run_solve(1, 2, 0, 0, 1'b0, "n_one");
    endtask

    task automatic test_zero_iter();
        run_solve(3, 0, 0, 1, 1'b0, "zero_iter");
    endtask

    task automatic test_noise();
        run_solve(3, 2, 0, 2, 1'b1, "noise");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 8; r++) begin
            int n, mi, ca;
            n  = int'($urandom_range(6, 1));
            mi = int'($urandom_range(4, 1));
            ca = int'($urandom_range(mi + 1, 0));
            run_solve(n, mi, ca, 3, 1'($urandom_range(1, 0)), $sformatf("rand%0d", r));
        end
    endtask

`ifdef JACOBI_SEQ_ABORT_EN
    task automatic test_abort();
        bit seen;
        do_reset();
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.n        = 8'd2;
        bus.max_iter = IW'(2);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.div_start) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || bus.done !== 1'b1 || bus.err !== 1'b1 || bus.converged !== 1'b0 || bus.iter_count !== '0) begin
            errors++;
            $display("FAIL abort got done=%0b err=%0b conv=%0b iter=%0d expected 1/1/0/0",
                     bus.done, bus.err, bus.converged, bus.iter_count);
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_plan_n2();
        test_reset_mid();
        test_converge();
        test_bad_n();
        test_zero_iter();
        test_noise();
        test_back_to_back();
`ifdef JACOBI_SEQ_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
